spi_adapter_arbiter: RTL and testbench

Shares one SPI minion adapter stream pair among `nreqs` on-chip requesters. The upstream path arbitrates round-robin among requesters. Each winner's data is tagged with its requester ID and presented to the adapter's `recv` port. The downstream path takes messages from the adapter's `send` port, decodes the ID tag and delivers the data to the addressed requester. The block sits between the adapter composite and the core-side clients.

---
 rtl/spi_adapter_arbiter.sv | 129 ++++++++++++
 tb/tb_spi_adapter_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_adapter_arbiter.sv
// spi_adapter_arbiter: round-robin upstream mux and ID-routed downstream
// demux sharing one SPI minion adapter stream pair among nreqs clients.
module spi_adapter_arbiter #(
    parameter int nbits = 8,
    parameter int nreqs = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [nreqs-1:0]                       req_val,
    output logic [nreqs-1:0]                       req_rdy,
    input  logic [nreqs*(nbits-2-$clog2(nreqs))-1:0] req_msg,
    input  logic [nreqs-1:0]                       req_en,
    output logic [nbits-3:0]                       adp_recv_msg,
    output logic                                   adp_recv_val,
    input  logic                                   adp_recv_rdy,
    input  logic [nbits-3:0]                       adp_send_msg,
    input  logic                                   adp_send_val,
    output logic                                   adp_send_rdy,
    output logic [nbits-3-$clog2(nreqs):0]         resp_msg,
    output logic [nreqs-1:0]                       resp_val,
    input  logic [nreqs-1:0]                       resp_rdy,
    output logic [7:0]                             drop_cnt
);
    localparam int PW = nbits - 2;
    localparam int IW = $clog2(nreqs);
    localparam int DW = PW - IW;

    logic             ovalid;
    logic [PW-1:0]    omsg;
    logic [IW-1:0]    ptr;
    logic [nreqs-1:0] elig;
    logic [IW-1:0]    win;
    logic [IW-1:0]    sel;
    logic             any;
    logic [DW-1:0]    win_data;
    logic             can_load;
    logic             up_fire;
    int               idx;

    assign elig     = req_val & req_en;
    assign can_load = ~ovalid | adp_recv_rdy;
    assign up_fire  = any & can_load;

    // Descending scan so the lowest offset from ptr wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        sel = '0;
        for (int k = nreqs - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= nreqs) idx = idx - nreqs;
            sel = IW'(idx);
            if (elig[sel]) begin
                win = sel;
                any = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < nreqs; i++) begin
            if (win == IW'(i)) win_data = req_msg[i*DW +: DW];
        end
    end

    assign req_rdy = (up_fire & reset) ? (nreqs'(1) << win) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovalid <= 1'b0;
            omsg   <= '0;
            ptr    <= '0;
        end else if (up_fire) begin
            ovalid <= 1'b1;
            omsg   <= {win, win_data};
            ptr    <= (32'(win) == nreqs - 1) ? '0 : win + 1'b1;
        end else if (adp_recv_rdy) begin
            ovalid <= 1'b0;
        end
    end

    assign adp_recv_val = ovalid;
    assign adp_recv_msg = omsg;

    logic          rvalid;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [IW-1:0] sid;
    logic          sid_ok;
    logic          dn_fire;
    logic          drain;

    assign sid = adp_send_msg[PW-1 -: IW];

    always_comb begin
        sid_ok = 1'b0;
        for (int i = 0; i < nreqs; i++) begin
            if (sid == IW'(i)) sid_ok = 1'b1;
        end
    end

    assign drain        = rvalid & resp_rdy[rid];
    assign adp_send_rdy = ~rvalid | resp_rdy[rid];
    assign dn_fire      = adp_send_val & adp_send_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid   <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            drop_cnt <= '0;
        end else begin
            if (dn_fire & sid_ok) begin
                rvalid <= 1'b1;
                rid    <= sid;
                rdata  <= adp_send_msg[DW-1:0];
            end else if (drain) begin
                rvalid <= 1'b0;
            end
            if (dn_fire & ~sid_ok & (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign resp_val = rvalid ? (nreqs'(1) << rid) : '0;
    assign resp_msg = rdata;
endmodule

// File: tb/tb_spi_adapter_arbiter.sv
// tb_spi_adapter_arbiter: directed stimulus with scoreboard queues for
// a 4-requester and a 3-requester instance.
module tb_spi_adapter_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req_val, req_rdy, req_en, resp_val, resp_rdy;
    logic [15:0] req_msg;
    logic [5:0]  adp_recv_msg, adp_send_msg;
    logic        adp_recv_val, adp_recv_rdy;
    logic        adp_send_val, adp_send_rdy;
    logic [3:0]  resp_msg;
    logic [7:0]  drop_cnt;

    logic [2:0]  req_val3, req_rdy3, req_en3, resp_val3, resp_rdy3;
    logic [11:0] req_msg3;
    logic [5:0]  adp_recv_msg3, adp_send_msg3;
    logic        adp_recv_val3, adp_recv_rdy3;
    logic        adp_send_val3, adp_send_rdy3;
    logic [3:0]  resp_msg3;
    logic [7:0]  drop_cnt3;

    spi_adapter_arbiter #(.nbits(8), .nreqs(4)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy),
        .req_msg(req_msg), .req_en(req_en),
        .adp_recv_msg(adp_recv_msg), .adp_recv_val(adp_recv_val),
        .adp_recv_rdy(adp_recv_rdy),
        .adp_send_msg(adp_send_msg), .adp_send_val(adp_send_val),
        .adp_send_rdy(adp_send_rdy),
        .resp_msg(resp_msg), .resp_val(resp_val),
        .resp_rdy(resp_rdy), .drop_cnt(drop_cnt)
    );

    spi_adapter_arbiter #(.nbits(8), .nreqs(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_val(req_val3), .req_rdy(req_rdy3),
        .req_msg(req_msg3), .req_en(req_en3),
        .adp_recv_msg(adp_recv_msg3), .adp_recv_val(adp_recv_val3),
        .adp_recv_rdy(adp_recv_rdy3),
        .adp_send_msg(adp_send_msg3), .adp_send_val(adp_send_val3),
        .adp_send_rdy(adp_send_rdy3),
        .resp_msg(resp_msg3), .resp_val(resp_val3),
        .resp_rdy(resp_rdy3), .drop_cnt(drop_cnt3)
    );

    int tests = 0;
    int fails = 0;
    int exp_win = -2;
    int exp_srdy = -1;
    int exp_srdy3 = -1;
    int d3 = 0;
    logic drop;
    logic [5:0] up_q[$];
    logic [7:0] dn_q[$];
    logic [6:0] dn3_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_msgs(input int n);
        for (int i = 0; i < 4; i++) req_msg[i*4 +: 4] = 4'(n * 4 + i);
    endtask

    task automatic mon();
        if (adp_recv_val) begin
            if (up_q.size() == 0) chk("up_unexpected", adp_recv_val, 0);
            else begin
                chk("up_msg", adp_recv_msg, up_q[0]);
                if (adp_recv_rdy) void'(up_q.pop_front());
            end
        end
        if (resp_val != 4'b0) begin
            if (dn_q.size() == 0) chk("dn_unexpected", resp_val, 0);
            else begin
                chk("dn_resp", {resp_val, resp_msg}, dn_q[0]);
                if ((resp_val & resp_rdy) != 4'b0) void'(dn_q.pop_front());
            end
        end
        if (resp_val3 != 3'b0) begin
            if (dn3_q.size() == 0) chk("dn3_unexpected", resp_val3, 0);
            else begin
                chk("dn3_resp", {resp_val3, resp_msg3}, dn3_q[0]);
                if ((resp_val3 & resp_rdy3) != 3'b0)
                    void'(dn3_q.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        if (exp_win >= 0) begin
            chk("req_rdy", req_rdy, 32'(1) << exp_win);
            up_q.push_back({exp_win[1:0], req_msg[exp_win*4 +: 4]});
        end else if (exp_win == -1) begin
            chk("req_rdy_idle", req_rdy, 0);
        end
        if (exp_srdy >= 0) chk("send_rdy", adp_send_rdy, exp_srdy);
        if (exp_srdy == 1 && adp_send_val)
            dn_q.push_back({4'b1 << adp_send_msg[5:4], adp_send_msg[3:0]});
        if (exp_srdy3 >= 0) chk("send_rdy3", adp_send_rdy3, exp_srdy3);
        if (exp_srdy3 == 1 && adp_send_val3 && adp_send_msg3[5:4] != 2'd3)
            dn3_q.push_back({3'b1 << adp_send_msg3[5:4], adp_send_msg3[3:0]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_val = '0; req_en = 4'hF; req_msg = '0; resp_rdy = 4'hF;
        adp_recv_rdy = 1'b1; adp_send_val = 1'b0; adp_send_msg = '0;
        req_val3 = '0; req_en3 = 3'h7; req_msg3 = '0; resp_rdy3 = 3'h7;
        adp_recv_rdy3 = 1'b1; adp_send_val3 = 1'b0; adp_send_msg3 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        req_val = 4'hF; set_msgs(0);
        adp_send_val = 1'b1; adp_send_msg = {2'd2, 4'h3};
        resp_rdy = 4'b1011;
        exp_win = 0; exp_srdy = 1; tick();
        adp_send_val = 1'b0; exp_srdy = -1; exp_win = 1; tick();

        reset = 1'b0;
        #1;
        chk("rst_recv_val", adp_recv_val, 0);
        chk("rst_recv_msg", adp_recv_msg, 0);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_resp_msg", resp_msg, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_drop3", drop_cnt3, 0);
        chk("rst_resp_val3", resp_val3, 0);
        up_q.delete(); dn_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        resp_rdy = 4'hF;

        exp_win = 0; tick();
        req_val = 4'b0100; req_msg[11:8] = 4'hA; exp_win = 2; tick();
        req_val = '0; exp_win = -1; tick();

        req_val = 4'hF;
        for (int i = 0; i < 8; i++) begin
            set_msgs(i + 1); exp_win = (3 + i) % 4; tick();
        end

        req_en = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            set_msgs(i + 5); exp_win = (i % 2 == 0) ? 3 : 1; tick();
        end
        req_en = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            set_msgs(i + 2); exp_win = 1; tick();
        end

        req_en = 4'hF; req_val = 4'b0001; exp_win = 0; tick();
        adp_recv_rdy = 1'b0; exp_win = -1;
        for (int i = 0; i < 5; i++) begin
            set_msgs(i + 9); tick();
        end
        adp_recv_rdy = 1'b1; exp_win = 0; tick();
        req_val = '0; exp_win = -1; tick(); tick();

        exp_win = -2;
        adp_send_val = 1'b1; adp_send_msg = {2'd1, 4'h5}; exp_srdy = 1;
        tick();
        adp_send_msg = {2'd3, 4'hC}; tick();
        resp_rdy = 4'b1101; adp_send_msg = {2'd1, 4'h7}; tick();
        adp_send_msg = {2'd2, 4'h9}; exp_srdy = 0;
        repeat (3) tick();
        resp_rdy = 4'hF; exp_srdy = 1; tick();
        adp_send_val = 1'b0; exp_srdy = -1; tick(); tick();

        adp_send_val3 = 1'b1; exp_srdy3 = 1;
        for (int i = 0; i < 320; i++) begin
            drop = (i % 40 != 20);
            if (drop) adp_send_msg3 = {2'd3, 4'(i)};
            else adp_send_msg3 = {2'(i % 3), 4'(i)};
            tick();
            if (drop && d3 < 255) d3++;
            if (i % 32 == 31) chk("drop_cnt_mid", drop_cnt3, d3);
        end
        adp_send_val3 = 1'b0; exp_srdy3 = -1; tick(); tick();

        chk("drop_sat", drop_cnt3, 255);
        chk("drop_none4", drop_cnt, 0);
        chk("up_q_empty", up_q.size(), 0);
        chk("dn_q_empty", dn_q.size(), 0);
        chk("dn3_q_empty", dn3_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
